// File: rtl/uart_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_param
// Description : Parametrised full-duplex UART. The Tx side serialises a frame
//               and the Rx side decodes an oversampled frame with parity and
//               framing checks. Optional macro UART_PARAM_LOOPBACK_EN adds an
//               internal loopback port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int PARITY_MODE    = 1,
    parameter int STOP_BITS      = 1,
    parameter int CLOCKS_PER_BIT = 8,
    parameter int NUM_SYNC       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef UART_PARAM_LOOPBACK_EN
    input  logic                  loopback,
`endif
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_busy,
    output logic                  serial_out,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] received_data,
    output logic                  data_is_valid,
    output logic                  rx_parity_error,
    output logic                  rx_framing_error
);
    localparam int c_cnt_w = $clog2(CLOCKS_PER_BIT);
    localparam int c_bit_w = $clog2(DATA_WIDTH);
    localparam logic c_par_en  = (PARITY_MODE != 0);
    localparam logic c_par_odd = (PARITY_MODE == 2);
    localparam logic c_stop_last = (STOP_BITS == 2);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLOCKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ---------------- Tx ----------------
    state_t                r_tx_state, w_tx_next;
    logic [c_cnt_w-1:0]    r_tx_cnt;
    logic [c_bit_w-1:0]    r_tx_bit;
    logic                  r_tx_stop;
    logic                  r_tx_par;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  w_tx_line;
    logic                  w_tx_end;

    assign w_tx_end = (r_tx_cnt == c_cnt_last);
    assign o_busy   = (r_tx_state != S_IDLE);

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_line = 1'b1;
        case (r_tx_state)
            S_IDLE: if (enable) w_tx_next = S_START;
            S_START: begin
                w_tx_line = 1'b0;
                if (w_tx_end) w_tx_next = S_DATA;
            end
            S_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (w_tx_end && r_tx_bit == c_bit_last)
                    w_tx_next = c_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                w_tx_line = r_tx_par;
                if (w_tx_end) w_tx_next = S_STOP;
            end
            S_STOP: if (w_tx_end && r_tx_stop == c_stop_last) w_tx_next = S_IDLE;
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_par   <= 1'b0;
            r_tx_shift <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            if (r_tx_state == S_IDLE) begin
                r_tx_cnt  <= '0;
                r_tx_bit  <= '0;
                r_tx_stop <= 1'b0;
                if (enable) begin
                    r_tx_shift <= i_data;
                    r_tx_par   <= (^i_data) ^ c_par_odd;
                end
            end else begin
                r_tx_cnt <= w_tx_end ? '0 : r_tx_cnt + 1'b1;
                if (w_tx_end && r_tx_state == S_DATA) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= r_tx_bit + 1'b1;
                end
                if (w_tx_end && r_tx_state == S_STOP) r_tx_stop <= ~r_tx_stop;
            end
        end
    end

    // ---------------- Rx ----------------
    logic                  w_rx_src;
    logic [NUM_SYNC-1:0]   r_sync;
    logic                  w_rx_s;
    logic                  r_rx_prev;
    state_t                r_rx_state, w_rx_next;
    logic [c_cnt_w-1:0]    r_rx_cnt;
    logic [c_bit_w-1:0]    r_rx_bit;
    logic                  r_rx_par;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic                  w_rx_end;
    logic                  w_rx_par_calc;

`ifdef UART_PARAM_LOOPBACK_EN
    assign w_rx_src   = loopback ? w_tx_line : serial_in;
    assign serial_out = loopback | w_tx_line;
`else
    assign w_rx_src   = serial_in;
    assign serial_out = w_tx_line;
`endif

    assign w_rx_s        = r_sync[NUM_SYNC-1];
    assign w_rx_end      = (r_rx_cnt == c_cnt_last);
    assign w_rx_par_calc = (^r_rx_shift) ^ c_par_odd;

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            S_IDLE:   if (!w_rx_s && r_rx_prev) w_rx_next = S_START;
            // Mid-bit recheck rejects glitches shorter than half a bit
            S_START:  if (r_rx_cnt == c_cnt_half) w_rx_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_rx_end && r_rx_bit == c_bit_last)
                          w_rx_next = c_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_rx_end) w_rx_next = S_STOP;
            S_STOP:   if (w_rx_end) w_rx_next = S_IDLE;
            default:  w_rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync           <= '1;
            r_rx_prev        <= 1'b1;
            r_rx_state       <= S_IDLE;
            r_rx_cnt         <= '0;
            r_rx_bit         <= '0;
            r_rx_par         <= 1'b0;
            r_rx_shift       <= '0;
            received_data    <= '0;
            data_is_valid    <= 1'b0;
            rx_parity_error  <= 1'b0;
            rx_framing_error <= 1'b0;
        end else begin
            r_sync        <= {r_sync[NUM_SYNC-2:0], w_rx_src};
            r_rx_prev     <= w_rx_s;
            r_rx_state    <= w_rx_next;
            data_is_valid <= 1'b0;
            case (r_rx_state)
                S_IDLE: begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= '0;
                end
                S_START: r_rx_cnt <= (r_rx_cnt == c_cnt_half) ? '0 : r_rx_cnt + 1'b1;
                default: begin
                    r_rx_cnt <= w_rx_end ? '0 : r_rx_cnt + 1'b1;
                    if (w_rx_end && r_rx_state == S_DATA) begin
                        r_rx_shift <= {w_rx_s, r_rx_shift[DATA_WIDTH-1:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                    end
                    if (w_rx_end && r_rx_state == S_PARITY) r_rx_par <= w_rx_s;
                    if (w_rx_end && r_rx_state == S_STOP) begin
                        received_data    <= r_rx_shift;
                        data_is_valid    <= 1'b1;
                        rx_parity_error  <= c_par_en && (r_rx_par != w_rx_par_calc);
                        rx_framing_error <= ~w_rx_s;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire
